// File: rtl/tdc_pkg.sv
// Shared types, field layout and calendar helpers for the time/date/alarm clock.
package tdc_pkg;

  localparam int TD_W    = 44;
  localparam int ALARM_W = 14;

  // Bit offsets of each BCD field inside the 44-bit time/date word
  localparam int SEC_U_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_U_LSB = 7;
  localparam int MIN_T_LSB = 11;
  localparam int HR_U_LSB  = 14;
  localparam int HR_T_LSB  = 18;
  localparam int DAY_U_LSB = 20;
  localparam int DAY_T_LSB = 24;
  localparam int MON_U_LSB = 26;
  localparam int MON_T_LSB = 30;
  localparam int YR_U_LSB  = 31;
  localparam int YR_T_LSB  = 35;
  localparam int WDAY_LSB  = 39;

  // Saturday 1 Jan 2000, 00:00:00
  localparam logic [TD_W-1:0] TD_RESET_VALUE =
    (44'd5 << WDAY_LSB) | (44'd1 << MON_U_LSB) | (44'd1 << DAY_U_LSB);

  typedef struct packed {
    logic [1:0] rsvd;
    logic [2:0] wday;
    logic [3:0] yrT;
    logic [3:0] yrU;
    logic       monT;
    logic [3:0] monU;
    logic [1:0] dayT;
    logic [3:0] dayU;
    logic [1:0] hrT;
    logic [3:0] hrU;
    logic [2:0] minT;
    logic [3:0] minU;
    logic [2:0] secT;
    logic [3:0] secU;
  } td_t;

  typedef struct packed {
    logic       en;
    logic [1:0] hrT;
    logic [3:0] hrU;
    logic [2:0] minT;
    logic [3:0] minU;
  } alarm_t;

  // Divisible-by-4 test done directly on the two BCD year digits
  function automatic logic is_leap(input logic [3:0] yearTens, input logic [3:0] yearUnits);
    if (!yearTens[0])
      return (yearUnits == 4'd0) || (yearUnits == 4'd4) || (yearUnits == 4'd8);
    else
      return (yearUnits == 4'd2) || (yearUnits == 4'd6);
  endfunction

  // Month length returned as two BCD digits {tens[1:0], units[3:0]}
  function automatic logic [5:0] days_in_month(input logic monthTens, input logic [3:0] monthUnits,
                                               input logic leap);
    logic [5:0] d;
    d = 6'h31;
    if (!monthTens) begin
      case (monthUnits)
        4'd2:              d = leap ? 6'h29 : 6'h28;
        4'd4, 4'd6, 4'd9:  d = 6'h30;
        default:           d = 6'h31;
      endcase
    end else if (monthUnits == 4'd1) begin
      d = 6'h30;
    end
    return d;
  endfunction

endpackage

// File: rtl/time_date_alarm_clock_if.sv
// UI-facing bus of the time/date/alarm clock: load, alarm programming and outputs.
interface time_date_alarm_clock_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic                          clkEn1Hz;
  logic                          setTimeAndDate_in;
  logic [tdc_pkg::TD_W-1:0]      timeAndDate_In;
  logic [tdc_pkg::TD_W-1:0]      timeAndDate_Out;
  logic                          setError_out;
  logic                          alarmWrEn_in;
  logic [IDX_W-1:0]              alarmIdx_in;
  logic [tdc_pkg::ALARM_W-1:0]   alarmTime_in;
  logic [NUM_ALARMS-1:0]         alarmFire_out;

  modport master (
    output clkEn1Hz, setTimeAndDate_in, timeAndDate_In,
    output alarmWrEn_in, alarmIdx_in, alarmTime_in,
    input  timeAndDate_Out, setError_out, alarmFire_out
  );

  modport slave (
    input  clkEn1Hz, setTimeAndDate_in, timeAndDate_In,
    input  alarmWrEn_in, alarmIdx_in, alarmTime_in,
    output timeAndDate_Out, setError_out, alarmFire_out
  );
endinterface

// File: rtl/tdc_field_validator.sv
// Combinational range check of a 44-bit BCD time/date word; reserved bits are ignored.
module tdc_field_validator
  import tdc_pkg::*;
(
  input  logic [TD_W-1:0] i_td,
  output logic            o_valid
);

  logic [3:0] w_secU, w_minU, w_hrU, w_dayU, w_monU, w_yrU, w_yrT;
  logic [2:0] w_secT, w_minT, w_wday;
  logic [1:0] w_hrT, w_dayT;
  logic       w_monT;
  logic [5:0] w_dim;
  logic       w_unused_rsvd;

  assign w_secU = i_td[SEC_U_LSB +: 4];
  assign w_secT = i_td[SEC_T_LSB +: 3];
  assign w_minU = i_td[MIN_U_LSB +: 4];
  assign w_minT = i_td[MIN_T_LSB +: 3];
  assign w_hrU  = i_td[HR_U_LSB  +: 4];
  assign w_hrT  = i_td[HR_T_LSB  +: 2];
  assign w_dayU = i_td[DAY_U_LSB +: 4];
  assign w_dayT = i_td[DAY_T_LSB +: 2];
  assign w_monU = i_td[MON_U_LSB +: 4];
  assign w_monT = i_td[MON_T_LSB];
  assign w_yrU  = i_td[YR_U_LSB  +: 4];
  assign w_yrT  = i_td[YR_T_LSB  +: 4];
  assign w_wday = i_td[WDAY_LSB  +: 3];
  assign w_unused_rsvd = ^i_td[TD_W-1:TD_W-2];

  assign w_dim = days_in_month(w_monT, w_monU, is_leap(w_yrT, w_yrU));

  // Any single out-of-range field makes the whole word invalid
  always_comb begin
    o_valid = 1'b1;
    if (w_secU > 4'd9 || w_secT > 3'd5) o_valid = 1'b0;
    if (w_minU > 4'd9 || w_minT > 3'd5) o_valid = 1'b0;
    if (w_hrU > 4'd9 || w_hrT > 2'd2 || (w_hrT == 2'd2 && w_hrU > 4'd3)) o_valid = 1'b0;
    if (w_monU > 4'd9) o_valid = 1'b0;
    if (!w_monT && w_monU == 4'd0) o_valid = 1'b0;
    if (w_monT && w_monU > 4'd2) o_valid = 1'b0;
    if (w_yrU > 4'd9 || w_yrT > 4'd9) o_valid = 1'b0;
    if (w_dayU > 4'd9) o_valid = 1'b0;
    if ({w_dayT, w_dayU} == 6'h00 || {w_dayT, w_dayU} > w_dim) o_valid = 1'b0;
    if (w_wday > 3'd6) o_valid = 1'b0;
  end

endmodule

// File: rtl/time_date_alarm_clock.sv
// BCD time/date/weekday counter advanced by a 1 Hz enable, with validated loading
// and NUM_ALARMS HH:MM alarm channels that pulse when a tick reaches HH:MM:00.
module time_date_alarm_clock
  import tdc_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    nReset,
  time_date_alarm_clock_if.slave  bus
);

  td_t                   r_td;
  logic                  r_setErr;
  logic [NUM_ALARMS-1:0] r_fire;
  alarm_t                r_alarm [NUM_ALARMS];

  logic                  w_setValid;
  td_t                   w_tick;
  logic [5:0]            w_dim;
  logic                  w_cMin, w_cHr, w_cDay, w_cMon, w_cYr;
  logic [NUM_ALARMS-1:0] w_match;

  tdc_field_validator u_validator (
    .i_td    (bus.timeAndDate_In),
    .o_valid (w_setValid)
  );

  assign w_dim = days_in_month(r_td.monT, r_td.monU, is_leap(r_td.yrT, r_td.yrU));

  // Next value after one second: ripple carry from seconds up to the year
  always_comb begin
    w_tick = r_td;
    w_cMin = 1'b0;
    w_cHr  = 1'b0;
    w_cDay = 1'b0;
    w_cMon = 1'b0;
    w_cYr  = 1'b0;

    if (r_td.secU == 4'd9) begin
      w_tick.secU = 4'd0;
      if (r_td.secT == 3'd5) begin
        w_tick.secT = 3'd0;
        w_cMin      = 1'b1;
      end else begin
        w_tick.secT = r_td.secT + 3'd1;
      end
    end else begin
      w_tick.secU = r_td.secU + 4'd1;
    end

    if (w_cMin) begin
      if (r_td.minU == 4'd9) begin
        w_tick.minU = 4'd0;
        if (r_td.minT == 3'd5) begin
          w_tick.minT = 3'd0;
          w_cHr       = 1'b1;
        end else begin
          w_tick.minT = r_td.minT + 3'd1;
        end
      end else begin
        w_tick.minU = r_td.minU + 4'd1;
      end
    end

    if (w_cHr) begin
      if (r_td.hrT == 2'd2 && r_td.hrU == 4'd3) begin
        w_tick.hrT = 2'd0;
        w_tick.hrU = 4'd0;
        w_cDay     = 1'b1;
      end else if (r_td.hrU == 4'd9) begin
        w_tick.hrU = 4'd0;
        w_tick.hrT = r_td.hrT + 2'd1;
      end else begin
        w_tick.hrU = r_td.hrU + 4'd1;
      end
    end

    if (w_cDay) begin
      w_tick.wday = (r_td.wday == 3'd6) ? 3'd0 : r_td.wday + 3'd1;
      if ({r_td.dayT, r_td.dayU} == w_dim) begin
        w_tick.dayT = 2'd0;
        w_tick.dayU = 4'd1;
        w_cMon      = 1'b1;
      end else if (r_td.dayU == 4'd9) begin
        w_tick.dayU = 4'd0;
        w_tick.dayT = r_td.dayT + 2'd1;
      end else begin
        w_tick.dayU = r_td.dayU + 4'd1;
      end
    end

    if (w_cMon) begin
      if (r_td.monT && r_td.monU == 4'd2) begin
        w_tick.monT = 1'b0;
        w_tick.monU = 4'd1;
        w_cYr       = 1'b1;
      end else if (r_td.monU == 4'd9) begin
        w_tick.monU = 4'd0;
        w_tick.monT = 1'b1;
      end else begin
        w_tick.monU = r_td.monU + 4'd1;
      end
    end

    if (w_cYr) begin
      if (r_td.yrU == 4'd9) begin
        w_tick.yrU = 4'd0;
        w_tick.yrT = (r_td.yrT == 4'd9) ? 4'd0 : r_td.yrT + 4'd1;
      end else begin
        w_tick.yrU = r_td.yrU + 4'd1;
      end
    end
  end

  // Alarm match against the post-tick value, using alarm contents before any same-cycle write
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      w_match[k] = r_alarm[k].en &&
                   w_tick.secT == 3'd0 && w_tick.secU == 4'd0 &&
                   {r_alarm[k].hrT, r_alarm[k].hrU, r_alarm[k].minT, r_alarm[k].minU} ==
                   {w_tick.hrT, w_tick.hrU, w_tick.minT, w_tick.minU};
    end
  end

  // State update: reset, then valid load (swallows the tick), else tick; alarm writes alongside
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_td     <= TD_RESET_VALUE;
      r_setErr <= 1'b0;
      r_fire   <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) r_alarm[k] <= '0;
    end else begin
      r_setErr <= 1'b0;
      r_fire   <= '0;
      if (bus.setTimeAndDate_in && w_setValid) begin
        r_td <= {2'b00, bus.timeAndDate_In[TD_W-3:0]};
      end else begin
        if (bus.setTimeAndDate_in) r_setErr <= 1'b1;
        if (bus.clkEn1Hz) begin
          r_td   <= w_tick;
          r_fire <= w_match;
        end
      end
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (bus.alarmWrEn_in && bus.alarmIdx_in == IDX_W'(k)) r_alarm[k] <= bus.alarmTime_in;
      end
    end
  end

  assign bus.timeAndDate_Out = r_td;
  assign bus.setError_out    = r_setErr;
  assign bus.alarmFire_out   = r_fire;

endmodule

// File: tb/tb_time_date_alarm_clock.sv
// Bench for time_date_alarm_clock: directed calendar/alarm scenarios followed by
// randomized traffic, all compared with an integer-arithmetic calendar model.
module tb_time_date_alarm_clock;
  import tdc_pkg::*;

  localparam int NA = 3;
  localparam int IW = 2;

  logic clk;
  logic nReset;
  logic rst_valid;
  int   n_checks = 0;
  int   n_errors = 0;

  time_date_alarm_clock_if #(.NUM_ALARMS(NA), .IDX_W(IW)) bus ();

  time_date_alarm_clock #(.NUM_ALARMS(NA), .IDX_W(IW)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  tdc_field_validator u_rst_chk (
    .i_td    (TD_RESET_VALUE),
    .o_valid (rst_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model state: plain integers
  int m_sec, m_min, m_hour, m_day, m_mon, m_year, m_wd;
  logic [13:0]   m_al [NA];
  logic          exp_err;
  logic [NA-1:0] exp_fire;

  function automatic logic [43:0] pack(int s, int mi, int h, int d, int mo, int y, int wd);
    logic [43:0] r;
    r = '0;
    r[3:0]   = 4'(s % 10);   r[6:4]   = 3'(s / 10);
    r[10:7]  = 4'(mi % 10);  r[13:11] = 3'(mi / 10);
    r[17:14] = 4'(h % 10);   r[19:18] = 2'(h / 10);
    r[23:20] = 4'(d % 10);   r[25:24] = 2'(d / 10);
    r[29:26] = 4'(mo % 10);  r[30]    = 1'(mo / 10);
    r[34:31] = 4'(y % 10);   r[38:35] = 4'(y / 10);
    r[41:39] = 3'(wd);
    return r;
  endfunction

  function automatic logic [13:0] at_code(bit en, int hh, int mm);
    return {en, 2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
  endfunction

  function automatic int fld(logic [43:0] td, int lsb, int w);
    return int'(td >> lsb) & ((1 << w) - 1);
  endfunction

  function automatic int dim(int mo, int y);
    case (mo)
      2:             return (y % 4 == 0) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic bit model_valid(logic [43:0] td);
    int su, st, mu, mt, hu, ht, du, dt, ou, ot, yu, yt, wd;
    int s, mi, h, d, mo, y;
    su = fld(td, 0, 4);  st = fld(td, 4, 3);
    mu = fld(td, 7, 4);  mt = fld(td, 11, 3);
    hu = fld(td, 14, 4); ht = fld(td, 18, 2);
    du = fld(td, 20, 4); dt = fld(td, 24, 2);
    ou = fld(td, 26, 4); ot = fld(td, 30, 1);
    yu = fld(td, 31, 4); yt = fld(td, 35, 4);
    wd = fld(td, 39, 3);
    if (su > 9 || mu > 9 || hu > 9 || du > 9 || ou > 9 || yu > 9 || yt > 9) return 1'b0;
    s = st * 10 + su; mi = mt * 10 + mu; h = ht * 10 + hu;
    d = dt * 10 + du; mo = ot * 10 + ou; y = yt * 10 + yu;
    if (s > 59 || mi > 59 || h > 23 || mo < 1 || mo > 12 || wd > 6) return 1'b0;
    if (d < 1 || d > dim(mo, y)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0; m_wd = 5;
    for (int k = 0; k < NA; k++) m_al[k] = '0;
  endtask

  task automatic model_load(logic [43:0] td);
    m_sec  = fld(td, 4, 3) * 10 + fld(td, 0, 4);
    m_min  = fld(td, 11, 3) * 10 + fld(td, 7, 4);
    m_hour = fld(td, 18, 2) * 10 + fld(td, 14, 4);
    m_day  = fld(td, 24, 2) * 10 + fld(td, 20, 4);
    m_mon  = fld(td, 30, 1) * 10 + fld(td, 26, 4);
    m_year = fld(td, 35, 4) * 10 + fld(td, 31, 4);
    m_wd   = fld(td, 39, 3);
  endtask

  task automatic model_tick();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0;
          m_wd = (m_wd + 1) % 7;
          m_day++;
          if (m_day > dim(m_mon, m_year)) begin
            m_day = 1; m_mon++;
            if (m_mon == 13) begin
              m_mon = 1;
              m_year = (m_year + 1) % 100;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    nReset                = 1'b1;
    bus.clkEn1Hz          = 1'b0;
    bus.setTimeAndDate_in = 1'b0;
    bus.timeAndDate_In    = '0;
    bus.alarmWrEn_in      = 1'b0;
    bus.alarmIdx_in       = '0;
    bus.alarmTime_in      = '0;
  endtask

  task automatic set_td(logic [43:0] td);
    bus.setTimeAndDate_in = 1'b1;
    bus.timeAndDate_In    = td;
  endtask

  task automatic wr_alarm(int idx, logic [13:0] a);
    bus.alarmWrEn_in = 1'b1;
    bus.alarmIdx_in  = IW'(idx);
    bus.alarmTime_in = a;
  endtask

  // One clock: capture inputs, advance model at the edge, compare just after it
  task automatic cyc();
    bit          mrst, mset, mtick, mwr;
    logic [43:0] tdin;
    int          idx;
    logic [13:0] at;
    logic [12:0] hhmm;
    mrst  = !nReset;
    mset  = bus.setTimeAndDate_in;
    mtick = bus.clkEn1Hz;
    mwr   = bus.alarmWrEn_in;
    tdin  = bus.timeAndDate_In;
    idx   = int'(bus.alarmIdx_in);
    at    = bus.alarmTime_in;
    exp_err  = 1'b0;
    exp_fire = '0;
    @(posedge clk);
    if (mrst) begin
      model_reset();
    end else begin
      if (mset && model_valid(tdin)) begin
        model_load(tdin);
      end else begin
        if (mset) exp_err = 1'b1;
        if (mtick) begin
          model_tick();
          hhmm = {2'(m_hour / 10), 4'(m_hour % 10), 3'(m_min / 10), 4'(m_min % 10)};
          if (m_sec == 0)
            for (int k = 0; k < NA; k++)
              if (m_al[k][13] && m_al[k][12:0] == hhmm) exp_fire[k] = 1'b1;
        end
      end
      if (mwr && idx < NA) m_al[idx] = at;
    end
    #1;
    check("td", 64'(bus.timeAndDate_Out), 64'(pack(m_sec, m_min, m_hour, m_day, m_mon, m_year, m_wd)));
    check("err", 64'(bus.setError_out), 64'(exp_err));
    check("fire", 64'(bus.alarmFire_out), 64'(exp_fire));
  endtask

  initial begin
    logic [43:0] td;
    logic [63:0] rnd;
    int          sel;

    model_reset();
    idle();
    nReset = 1'b0;
    cyc();
    cyc();
    check("rst_td", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 1, 1, 0, 5)));
    check("rst_const_valid", 64'(rst_valid), 64'd1);

    // Year rollover
    idle(); set_td(pack(59, 59, 23, 31, 12, 99, 4)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("newyear", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 1, 1, 0, 5)));

    // Leap and non-leap February
    idle(); set_td(pack(59, 59, 23, 28, 2, 24, 2)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("leap29", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 29, 2, 24, 3)));
    idle(); set_td(pack(59, 59, 23, 28, 2, 23, 1)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("nonleap", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 1, 3, 23, 2)));
    idle(); set_td(pack(0, 0, 12, 29, 2, 23, 0)); cyc();
    check("feb29_rej", 64'(bus.setError_out), 64'd1);
    check("feb29_hold", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 1, 3, 23, 2)));
    idle(); cyc();
    check("err_once", 64'(bus.setError_out), 64'd0);

    // Two channels armed at 07:30
    idle(); wr_alarm(2, at_code(1'b1, 7, 30)); cyc();
    idle(); wr_alarm(0, at_code(1'b1, 7, 30)); cyc();
    idle(); set_td(pack(58, 29, 7, 10, 5, 24, 4)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("fire_101", 64'(bus.alarmFire_out), 64'(3'b101));
    idle(); cyc();
    check("fire_pulse", 64'(bus.alarmFire_out), 64'd0);

    // Loading a matching time does not fire; set beats a coincident tick
    idle(); set_td(pack(0, 30, 7, 10, 5, 24, 4)); cyc();
    check("set_nofire", 64'(bus.alarmFire_out), 64'd0);
    idle(); set_td(pack(10, 20, 12, 15, 6, 24, 5)); bus.clkEn1Hz = 1'b1; cyc();
    check("set_tick", 64'(bus.timeAndDate_Out), 64'(pack(10, 20, 12, 15, 6, 24, 5)));

    // Mid-count reset disarms the alarms
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    idle(); nReset = 1'b0; bus.clkEn1Hz = 1'b1; cyc();
    check("midrst_td", 64'(bus.timeAndDate_Out), 64'(pack(0, 0, 0, 1, 1, 0, 5)));
    idle(); set_td(pack(59, 29, 7, 1, 1, 0, 5)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("midrst_nofire", 64'(bus.alarmFire_out), 64'd0);

    // Out-of-range channel index is dropped
    idle(); wr_alarm(3, at_code(1'b1, 0, 1)); cyc();
    idle(); set_td(pack(59, 0, 0, 2, 1, 0, 6)); cyc();
    idle(); bus.clkEn1Hz = 1'b1; cyc();
    check("idx3_ignored", 64'(bus.alarmFire_out), 64'd0);

    // Non-BCD hour digit is rejected
    td = pack(0, 0, 10, 1, 1, 0, 5);
    td[17:14] = 4'hA;
    idle(); set_td(td); cyc();
    check("hour_nonbcd", 64'(bus.setError_out), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      nReset       = ($urandom_range(0, 199) != 0);
      bus.clkEn1Hz = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) begin
          rnd = {$urandom, $urandom};
          td  = rnd[43:0];
        end else if (sel == 1) begin
          td = pack($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 23),
                    $urandom_range(1, 31), $urandom_range(1, 12), $urandom_range(0, 99),
                    $urandom_range(0, 6));
        end else begin
          td = pack($urandom_range(55, 59), 59, $urandom_range(22, 23), $urandom_range(27, 31),
                    $urandom_range(1, 12), $urandom_range(0, 99), $urandom_range(0, 6));
        end
        set_td(td);
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 4) == 0)
          wr_alarm($urandom_range(0, 3), 14'($urandom));
        else
          wr_alarm($urandom_range(0, 3),
                   at_code($urandom_range(0, 5) != 0, m_hour, (m_min + $urandom_range(0, 1)) % 60));
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
